// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states,
// forward-select codes and the stall-need levels, plus the helper that
// turns producer matches into an EX operand select.
package hazard_ctrl_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] NEED_NONE = 2'd0;
  localparam logic [1:0] NEED_ONE  = 2'd1;
  localparam logic [1:0] NEED_TWO  = 2'd2;

  // A non-load producer one stage ahead is closest and wins; otherwise the
  // producer two stages ahead; otherwise the register file value is fine.
  function automatic logic [1:0] fwd_sel(input logic ex_alu_hit, input logic mem_hit);
    if (ex_alu_hit) begin
      return FWD_MEM;
    end
    if (mem_hit) begin
      return FWD_WB;
    end
    return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_ctrl_reg_match.sv
// Combinational index comparator for one source/producer pair. x0 and
// unused sources never match, and a producer that does not write a register
// never matches.
module hazard_ctrl_reg_match #(
  parameter int W = 5
) (
  input  logic [W-1:0] src,
  input  logic         use_src,
  input  logic [W-1:0] dst,
  input  logic         wr_en,
  output logic         hit
);

  assign hit = use_src && wr_en && (src != '0) && (src == dst);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: stall, flush and
// forward-select generation plus a stall-cycle performance counter.
// Build option: define FORWARD_EN to enable the forwarding network, in which
// case only load-use hazards stall (one bubble). Without it every RAW hazard
// stalls until the producer reaches WB and the forward selects stay 00.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] i_Rs1D,
  input  logic [REG_ADDR_W-1:0] i_Rs2D,
  input  logic                  i_UseRs1D,
  input  logic                  i_UseRs2D,
  input  logic [REG_ADDR_W-1:0] i_RdE,
  input  logic                  i_RegWrE,
  input  logic                  i_LoadE,
  input  logic [REG_ADDR_W-1:0] i_RdM,
  input  logic                  i_RegWrM,
  input  logic                  i_Boj,
  output logic                  o_StallF,
  output logic                  o_StallD,
  output logic                  o_FlushD,
  output logic                  o_FlushE,
  output logic [1:0]            o_Fwd1E,
  output logic [1:0]            o_Fwd2E,
  output logic [CNT_W-1:0]      o_StallCnt
);

  logic       hit1_e, hit2_e, hit1_m, hit2_m;
  logic       ex_hit, mem_hit;
  logic [1:0] need;
  state_t     state, state_next;
  logic [1:0] cnt, cnt_next;

  hazard_ctrl_reg_match #(.W(REG_ADDR_W)) u_match_1e (
    .src(i_Rs1D), .use_src(i_UseRs1D), .dst(i_RdE), .wr_en(i_RegWrE), .hit(hit1_e)
  );
  hazard_ctrl_reg_match #(.W(REG_ADDR_W)) u_match_2e (
    .src(i_Rs2D), .use_src(i_UseRs2D), .dst(i_RdE), .wr_en(i_RegWrE), .hit(hit2_e)
  );
  hazard_ctrl_reg_match #(.W(REG_ADDR_W)) u_match_1m (
    .src(i_Rs1D), .use_src(i_UseRs1D), .dst(i_RdM), .wr_en(i_RegWrM), .hit(hit1_m)
  );
  hazard_ctrl_reg_match #(.W(REG_ADDR_W)) u_match_2m (
    .src(i_Rs2D), .use_src(i_UseRs2D), .dst(i_RdM), .wr_en(i_RegWrM), .hit(hit2_m)
  );

  assign ex_hit  = hit1_e | hit2_e;
  assign mem_hit = hit1_m | hit2_m;

  // How many stall cycles the instruction in ID needs before it may enter EX.
  always_comb begin
    need = NEED_NONE;
`ifdef FORWARD_EN
    if (ex_hit && i_LoadE) begin
      need = NEED_ONE;
    end
`else
    if (ex_hit) begin
      need = NEED_TWO;
    end else if (mem_hit) begin
      need = NEED_ONE;
    end
`endif
  end

  // State and hold down-counter; reset drops straight back to RUN.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state and stall/flush outputs; a taken branch/jump overrides any
  // stall because the ID instruction is on the wrong path.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    o_StallF   = 1'b0;
    o_StallD   = 1'b0;
    o_FlushD   = 1'b0;
    o_FlushE   = 1'b0;
    if (!rst_n) begin
      if (i_Boj) begin
        o_FlushD   = 1'b1;
        o_FlushE   = 1'b1;
        cnt_next   = '0;
        state_next = ST_RUN;
      end else begin
        case (state)
          ST_RUN: begin
            if (need != NEED_NONE) begin
              o_StallF = 1'b1;
              o_StallD = 1'b1;
              o_FlushE = 1'b1;
              if (need == NEED_TWO) begin
                cnt_next   = 2'd1;
                state_next = ST_HOLD;
              end
            end
          end
          ST_HOLD: begin
            o_StallF = 1'b1;
            o_StallD = 1'b1;
            o_FlushE = 1'b1;
            if (cnt > 2'd1) begin
              cnt_next = cnt - 2'd1;
            end else begin
              cnt_next   = '0;
              state_next = ST_RUN;
            end
          end
          default: begin
            cnt_next   = '0;
            state_next = ST_RUN;
          end
        endcase
      end
    end
  end

`ifdef FORWARD_EN
  // Forward selects for the instruction entering EX; a bubble gets 00.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      o_Fwd1E <= FWD_REG;
      o_Fwd2E <= FWD_REG;
    end else if (o_FlushE || o_StallD) begin
      o_Fwd1E <= FWD_REG;
      o_Fwd2E <= FWD_REG;
    end else begin
      o_Fwd1E <= fwd_sel(hit1_e && !i_LoadE, hit1_m);
      o_Fwd2E <= fwd_sel(hit2_e && !i_LoadE, hit2_m);
    end
  end
`else
  // Without forwarding EX always reads the register file; the load flag
  // only matters for forwarding, so it is deliberately left unused here.
  logic unused_load;
  assign unused_load = i_LoadE;
  assign o_Fwd1E     = FWD_REG;
  assign o_Fwd2E     = FWD_REG;
`endif

  // Count every cycle the IF-ID register is held; wraps naturally.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      o_StallCnt <= '0;
    end else if (o_StallD) begin
      o_StallCnt <= o_StallCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed literal cases followed by
// randomized traffic compared against a remaining-stall-cycles model.
module tb_hazard_ctrl;

  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 32;
`ifdef FORWARD_EN
  localparam logic [31:0] DIR_CNT = 32'd1;
`else
  localparam logic [31:0] DIR_CNT = 32'd3;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [REG_ADDR_W-1:0] rs1D, rs2D, rdE, rdM;
  logic                  useRs1D, useRs2D, regWrE, loadE, regWrM, boj;
  logic                  stallF, stallD, flushD, flushE;
  logic [1:0]            fwd1E, fwd2E;
  logic [CNT_W-1:0]      stallCnt;

  int checks   = 0;
  int failures = 0;

  hazard_ctrl #(.REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_Rs1D(rs1D), .i_Rs2D(rs2D), .i_UseRs1D(useRs1D), .i_UseRs2D(useRs2D),
    .i_RdE(rdE), .i_RegWrE(regWrE), .i_LoadE(loadE),
    .i_RdM(rdM), .i_RegWrM(regWrM), .i_Boj(boj),
    .o_StallF(stallF), .o_StallD(stallD), .o_FlushD(flushD), .o_FlushE(flushE),
    .o_Fwd1E(fwd1E), .o_Fwd2E(fwd2E), .o_StallCnt(stallCnt)
  );

  always #5 clk = ~clk;

  function automatic bit matchOf(input logic [4:0] src, input bit useSrc,
                                 input logic [4:0] dst, input bit wr);
    return useSrc && wr && (src != 5'd0) && (src == dst);
  endfunction

  task automatic checkValue(input string name, input logic [31:0] actual,
                            input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change on the falling edge and settle well before the rising edge.
  task automatic applyStimulus(input bit r, input logic [4:0] s1, input bit u1,
                               input logic [4:0] s2, input bit u2,
                               input logic [4:0] dE, input bit wE, input bit ldE,
                               input logic [4:0] dM, input bit wM, input bit b);
    @(negedge clk);
    rst_n = r; rs1D = s1; useRs1D = u1; rs2D = s2; useRs2D = u2;
    rdE = dE; regWrE = wE; loadE = ldE; rdM = dM; regWrM = wM; boj = b;
    #2;
  endtask

  task automatic checkOutput(input string name, input bit eF, input bit eD,
                             input bit eFD, input bit eFE, input logic [1:0] eW1,
                             input logic [1:0] eW2, input logic [31:0] eCnt);
    checkValue({name, ".StallF"}, 32'(stallF), 32'(eF));
    checkValue({name, ".StallD"}, 32'(stallD), 32'(eD));
    checkValue({name, ".FlushD"}, 32'(flushD), 32'(eFD));
    checkValue({name, ".FlushE"}, 32'(flushE), 32'(eFE));
    checkValue({name, ".Fwd1E"}, 32'(fwd1E), 32'(eW1));
    checkValue({name, ".Fwd2E"}, 32'(fwd2E), 32'(eW2));
    checkValue({name, ".StallCnt"}, stallCnt, eCnt);
  endtask

  initial begin
    int          holdLeft;
    logic [1:0]  fwd1Exp, fwd2Exp;
    logic [31:0] cntExp;

    // Reset with a live hazard on the inputs: everything must read zero.
    applyStimulus(1, 5, 1, 0, 0, 5, 1, 0, 0, 0, 0);
    checkOutput("reset", 0, 0, 0, 0, 2'b00, 2'b00, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("idle", 0, 0, 0, 0, 2'b00, 2'b00, 0);

`ifdef FORWARD_EN
    // lw x5 in EX, add x6,x5,x1 in ID.
    applyStimulus(0, 5, 1, 1, 1, 5, 1, 1, 0, 0, 0);
    checkOutput("ldu_c1", 1, 1, 0, 1, 2'b00, 2'b00, 0);
    applyStimulus(0, 5, 1, 1, 1, 0, 0, 0, 5, 1, 0);
    checkOutput("ldu_c2", 0, 0, 0, 0, 2'b00, 2'b00, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ldu_fwd", 0, 0, 0, 0, 2'b01, 2'b00, 1);
    // add x5 in EX, sub x7,x5,x5 in ID.
    applyStimulus(0, 5, 1, 5, 1, 5, 1, 0, 0, 0, 0);
    checkOutput("alu_c1", 0, 0, 0, 0, 2'b00, 2'b00, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("alu_fwd", 0, 0, 0, 0, 2'b10, 2'b10, 1);
`else
    // add x5 in EX, sub x7,x5,x5 in ID: two stall cycles.
    applyStimulus(0, 5, 1, 5, 1, 5, 1, 0, 0, 0, 0);
    checkOutput("raw_ex_c1", 1, 1, 0, 1, 2'b00, 2'b00, 0);
    applyStimulus(0, 5, 1, 5, 1, 0, 0, 0, 5, 1, 0);
    checkOutput("raw_ex_c2", 1, 1, 0, 1, 2'b00, 2'b00, 1);
    applyStimulus(0, 5, 1, 5, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("raw_ex_done", 0, 0, 0, 0, 2'b00, 2'b00, 2);
    // Producer already in MEM: one stall cycle.
    applyStimulus(0, 3, 1, 0, 0, 0, 0, 0, 3, 1, 0);
    checkOutput("raw_mem", 1, 1, 0, 1, 2'b00, 2'b00, 2);
    applyStimulus(0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("raw_mem_done", 0, 0, 0, 0, 2'b00, 2'b00, 3);
`endif

    // x0 never matches, nor does an unused source.
    applyStimulus(0, 0, 1, 0, 1, 0, 1, 1, 0, 1, 0);
    checkOutput("x0", 0, 0, 0, 0, 2'b00, 2'b00, DIR_CNT);
    applyStimulus(0, 0, 0, 4, 0, 4, 1, 1, 4, 1, 0);
    checkOutput("unused_src", 0, 0, 0, 0, 2'b00, 2'b00, DIR_CNT);
    // Load-use hazard with a taken branch: flush wins, nothing counted.
    applyStimulus(0, 5, 1, 0, 0, 5, 1, 1, 0, 0, 1);
    checkOutput("boj_hazard", 0, 0, 1, 1, 2'b00, 2'b00, DIR_CNT);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("boj_cnt", 0, 0, 0, 0, 2'b00, 2'b00, DIR_CNT);

`ifdef FORWARD_EN
    applyStimulus(0, 5, 1, 0, 0, 5, 1, 1, 0, 0, 0);
    checkOutput("rst_stall_c1", 1, 1, 0, 1, 2'b00, 2'b00, 1);
    applyStimulus(1, 5, 1, 0, 0, 5, 1, 1, 0, 0, 0);
    checkOutput("rst_in_stall", 0, 0, 0, 0, 2'b00, 2'b00, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_after", 0, 0, 0, 0, 2'b00, 2'b00, 0);
`else
    // Branch during HOLD cancels the remaining stall.
    applyStimulus(0, 6, 1, 0, 0, 6, 1, 0, 0, 0, 0);
    checkOutput("hold_c1", 1, 1, 0, 1, 2'b00, 2'b00, 3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("hold_boj", 0, 0, 1, 1, 2'b00, 2'b00, 4);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("hold_boj_after", 0, 0, 0, 0, 2'b00, 2'b00, 4);
    // HOLD stalls even with quiet inputs.
    applyStimulus(0, 6, 1, 0, 0, 6, 1, 0, 0, 0, 0);
    checkOutput("hold_ign_c1", 1, 1, 0, 1, 2'b00, 2'b00, 4);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("hold_ign_c2", 1, 1, 0, 1, 2'b00, 2'b00, 5);
    // Reset pulsed while in HOLD.
    applyStimulus(0, 6, 1, 0, 0, 6, 1, 0, 0, 0, 0);
    checkOutput("rst_hold_c1", 1, 1, 0, 1, 2'b00, 2'b00, 6);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_in_hold", 0, 0, 0, 0, 2'b00, 2'b00, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_after", 0, 0, 0, 0, 2'b00, 2'b00, 0);
`endif

    // Randomized traffic against the remaining-stall-cycles model.
    holdLeft = 0;
    fwd1Exp  = 2'b00;
    fwd2Exp  = 2'b00;
    cntExp   = 32'd0;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rand_start", 0, 0, 0, 0, 2'b00, 2'b00, 0);
    for (int n = 0; n < 3000; n++) begin
      bit          r, u1, u2, wE, ldE, wM, b;
      logic [4:0]  s1, s2, dE, dM;
      bit          e1, e2, m1, m2, expF, expD, expFD, expFE;
      int          need, nextHold;
      r   = ($urandom_range(0, 99) == 0);
      s1  = 5'($urandom_range(0, 3));
      s2  = 5'($urandom_range(0, 3));
      dE  = 5'($urandom_range(0, 3));
      dM  = 5'($urandom_range(0, 3));
      u1  = 1'($urandom_range(0, 1));
      u2  = 1'($urandom_range(0, 1));
      wE  = 1'($urandom_range(0, 1));
      ldE = 1'($urandom_range(0, 1));
      wM  = 1'($urandom_range(0, 1));
      b   = ($urandom_range(0, 7) == 0);
      applyStimulus(r, s1, u1, s2, u2, dE, wE, ldE, dM, wM, b);
      if (r) begin
        holdLeft = 0;
        fwd1Exp  = 2'b00;
        fwd2Exp  = 2'b00;
        cntExp   = 32'd0;
        checkOutput("rand_reset", 0, 0, 0, 0, 2'b00, 2'b00, 0);
        continue;
      end
      e1 = matchOf(s1, u1, dE, wE);
      e2 = matchOf(s2, u2, dE, wE);
      m1 = matchOf(s1, u1, dM, wM);
      m2 = matchOf(s2, u2, dM, wM);
      expFD = 0;
      if (b) begin
        expF = 0; expD = 0; expFD = 1; expFE = 1;
        nextHold = 0;
      end else if (holdLeft > 0) begin
        expF = 1; expD = 1; expFE = 1;
        nextHold = holdLeft - 1;
      end else begin
`ifdef FORWARD_EN
        need = ((e1 || e2) && ldE) ? 1 : 0;
`else
        need = (e1 || e2) ? 2 : ((m1 || m2) ? 1 : 0);
`endif
        expF = (need > 0); expD = (need > 0); expFE = (need > 0);
        nextHold = (need > 0) ? need - 1 : 0;
      end
      checkOutput("rand", expF, expD, expFD, expFE, fwd1Exp, fwd2Exp, cntExp);
      cntExp   = cntExp + 32'(expD);
      holdLeft = nextHold;
      fwd1Exp  = 2'b00;
      fwd2Exp  = 2'b00;
`ifdef FORWARD_EN
      if (!expFE && !expD) begin
        fwd1Exp = (e1 && !ldE) ? 2'b10 : (m1 ? 2'b01 : 2'b00);
        fwd2Exp = (e2 && !ldE) ? 2'b10 : (m2 ? 2'b01 : 2'b00);
      end
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
